gray_step_decoder: RTL and testbench



---
 rtl/gray_pkg.sv | 21 ++
 rtl/gray_to_bin.sv | 17 +
 rtl/gray_step_decoder.sv | 118 +++++++++++
 tb/tb_gray_step_decoder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the 3-bit Gray counter interface: state encoding,
// default bus width and a reference Gray-to-binary conversion.
package gray_pkg;

  localparam int GRAY_WIDTH = 3;

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } state_t;

  function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] g);
    logic [GRAY_WIDTH-1:0] b;
    b = g;
    for (int i = GRAY_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: MSB passes through, each lower bit
// is the xor of the binary bit above it and its own Gray bit.
module gray_to_bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = gray;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_step_decoder.sv
// Receive side of the Gray counter link: synchronizes the Gray bus, decodes it
// and turns single-code moves into up/down steps on a wrapping position.
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = GRAY_WIDTH,
  parameter int POS_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     G,
  input  logic                 EN,
  input  logic                 CLR,
  output logic [WIDTH-1:0]     B,
  output logic                 DIR,
  output logic                 STEP,
  output logic                 ERR,
  output logic                 ERR_P,
  output logic                 VALID,
  output logic [POS_WIDTH-1:0] POS
);

  localparam logic [WIDTH-1:0] DELTA_UP = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_d;
  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     gb;
  logic [WIDTH-1:0]     delta;
  logic [WIDTH-1:0]     b_d;
  logic                 dir_d, step_d, err_d, errp_d, valid_d;
  logic [POS_WIDTH-1:0] pos_d;

  // Only whole-code transitions of G are meaningful; the chain runs regardless of EN.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= G;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .gray (sync_q[SYNC_STAGES-1]),
    .bin  (gb)
  );

  assign delta = gb - B;

  always_comb begin
    state_d = state;
    b_d     = B;
    dir_d   = DIR;
    step_d  = 1'b0;
    errp_d  = 1'b0;
    err_d   = ERR;
    valid_d = VALID;
    pos_d   = POS;
    case (state)
      ST_INIT: begin
        if (EN) begin
          b_d     = gb;
          valid_d = 1'b1;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (EN) begin
          if (delta == DELTA_UP) begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = POS + POS_WIDTH'(1);
            b_d    = gb;
          end else if (delta == '1) begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = POS - POS_WIDTH'(1);
            b_d    = gb;
          end else if (delta != '0) begin
            // Multi-code jump: re-reference on the new value so tracking can resume.
            errp_d = 1'b1;
            err_d  = 1'b1;
            b_d    = gb;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (CLR) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      B     <= '0;
      DIR   <= 1'b0;
      STEP  <= 1'b0;
      ERR   <= 1'b0;
      ERR_P <= 1'b0;
      VALID <= 1'b0;
      POS   <= '0;
    end else begin
      state <= state_d;
      B     <= b_d;
      DIR   <= dir_d;
      STEP  <= step_d;
      ERR   <= err_d;
      ERR_P <= errp_d;
      VALID <= valid_d;
      POS   <= pos_d;
    end
  end

endmodule

// File: tb/tb_gray_step_decoder.sv
// Scoreboard bench for gray_step_decoder: each Gray move queues its expected
// pulse, and a negedge monitor pops and compares whenever STEP or ERR_P fires.
module tb_gray_step_decoder;

  typedef struct packed {
    logic       step;
    logic       errp;
    logic       dir;
    logic [7:0] pos;
    logic [2:0] b;
    logic       err;
  } ev_t;

  logic       CLK;
  logic       reset_n;
  logic [2:0] G;
  logic       EN;
  logic       CLR;
  logic [2:0] B;
  logic       DIR;
  logic       STEP;
  logic       ERR;
  logic       ERR_P;
  logic       VALID;
  logic [7:0] POS;

  int   checks = 0;
  int   fails = 0;
  int   steps_seen = 0;
  ev_t  sb[$];
  int   g2b_tab[8] = '{0, 1, 3, 2, 7, 6, 4, 5};
  int   exp_b, exp_pos, exp_dir, exp_err;

  gray_step_decoder #(.WIDTH(3), .POS_WIDTH(8), .SYNC_STAGES(2)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .G       (G),
    .EN      (EN),
    .CLR     (CLR),
    .B       (B),
    .DIR     (DIR),
    .STEP    (STEP),
    .ERR     (ERR),
    .ERR_P   (ERR_P),
    .VALID   (VALID),
    .POS     (POS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Any pulse must match the oldest queued expectation; a pulse with nothing queued is an error.
  always @(negedge CLK) begin
    if (STEP || ERR_P) begin
      ev_t e;
      checks++;
      if (STEP) steps_seen++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_pulse: step=%0b errp=%0b pos=%0d b=%0d, required no pulse", STEP, ERR_P, POS, B);
      end else begin
        e = sb.pop_front();
        if ({STEP, ERR_P, DIR, POS, B, ERR} !== e) begin
          fails++;
          $display("[TB] FAIL pulse: got step=%0b errp=%0b dir=%0b pos=%0d b=%0d err=%0b, required step=%0b errp=%0b dir=%0b pos=%0d b=%0d err=%0b",
                   STEP, ERR_P, DIR, POS, B, ERR, e.step, e.errp, e.dir, e.pos, e.b, e.err);
        end
      end
    end
  end

  task automatic move_g(input logic [2:0] g);
    int  nb, d, qn;
    ev_t e;
    nb = g2b_tab[g];
    d  = (nb - exp_b) & 7;
    e  = '0;
    if (d == 1) begin
      exp_pos = (exp_pos + 1) & 255;
      exp_dir = 1;
      e.step  = 1'b1;
    end else if (d == 7) begin
      exp_pos = (exp_pos - 1) & 255;
      exp_dir = 0;
      e.step  = 1'b1;
    end else if (d != 0) begin
      exp_err = 1;
      e.errp  = 1'b1;
    end
    exp_b = nb;
    e.dir = exp_dir[0];
    e.pos = exp_pos[7:0];
    e.b   = exp_b[2:0];
    e.err = exp_err[0];
    if (d != 0) sb.push_back(e);
    qn = sb.size();
    G = g;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != qn) begin
      fails++;
      $display("[TB] FAIL early_pulse: queue=%0d, required %0d", sb.size(), qn);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (d != 0 && sb.size() != qn - 1) begin
      fails++;
      $display("[TB] FAIL latency: queue=%0d, required %0d", sb.size(), qn - 1);
    end
    @(negedge CLK);
  endtask

  task automatic do_clr();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    exp_pos = 0;
    exp_err = 0;
    #1;
    checks++;
    if (POS !== 8'd0 || ERR !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clr: pos=%0d err=%0b, required pos=0 err=0", POS, ERR);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    G = 3'b101;
    EN = 1'b0;
    CLR = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({B, DIR, STEP, ERR, ERR_P, VALID, POS} !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: b=%0d dir=%0b step=%0b err=%0b errp=%0b valid=%0b pos=%0d, required all 0",
               B, DIR, STEP, ERR, ERR_P, VALID, POS);
    end
    reset_n = 1'b1;
    G = 3'b000;
    repeat (4) @(negedge CLK);
    checks++;
    if (VALID !== 1'b0) begin
      fails++;
      $display("[TB] FAIL init_hold: valid=%0b, required 0", VALID);
    end
    EN = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if (VALID !== 1'b1 || B !== 3'd0 || POS !== 8'd0 || STEP !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reference: valid=%0b b=%0d pos=%0d step=%0b, required valid=1 b=0 pos=0 step=0", VALID, B, POS, STEP);
    end
    repeat (3) @(negedge CLK);
    exp_b = 0; exp_pos = 0; exp_dir = 0; exp_err = 0;
  endtask

  task automatic test_up_sweep();
    logic [2:0] codes [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    int start;
    start = steps_seen;
    foreach (codes[i]) move_g(codes[i]);
    checks++;
    if (steps_seen - start != 8 || POS !== 8'd8 || DIR !== 1'b1 || B !== 3'd0) begin
      fails++;
      $display("[TB] FAIL up_sweep: steps=%0d pos=%0d dir=%0b b=%0d, required steps=8 pos=8 dir=1 b=0",
               steps_seen - start, POS, DIR, B);
    end
  endtask

  task automatic test_down_sweep();
    do_clr();
    move_g(3'b100);
    move_g(3'b101);
    move_g(3'b111);
    checks++;
    if (POS !== 8'd253 || DIR !== 1'b0 || B !== 3'd5) begin
      fails++;
      $display("[TB] FAIL down_sweep: pos=%0d dir=%0b b=%0d, required pos=253 dir=0 b=5", POS, DIR, B);
    end
  endtask

  task automatic test_illegal_jump();
    move_g(3'b110);
    move_g(3'b010);
    move_g(3'b011);
    move_g(3'b001);
    move_g(3'b110);
    checks++;
    if (ERR !== 1'b1 || B !== 3'd4 || POS !== 8'd249) begin
      fails++;
      $display("[TB] FAIL illegal_jump: err=%0b b=%0d pos=%0d, required err=1 b=4 pos=249", ERR, B, POS);
    end
    move_g(3'b111);
    checks++;
    if (ERR !== 1'b1 || POS !== 8'd250 || DIR !== 1'b1) begin
      fails++;
      $display("[TB] FAIL after_jump: err=%0b pos=%0d dir=%0b, required err=1 pos=250 dir=1", ERR, POS, DIR);
    end
  endtask

  task automatic test_clr_step();
    ev_t e;
    do_clr();
    move_g(3'b101);
    move_g(3'b100);
    move_g(3'b000);
    move_g(3'b001);
    move_g(3'b011);
    move_g(3'b111);
    checks++;
    if (POS !== 8'd5 || ERR !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pre_clr: pos=%0d err=%0b, required pos=5 err=1", POS, ERR);
    end
    exp_b = 6; exp_pos = 0; exp_dir = 1; exp_err = 0;
    e = '0;
    e.step = 1'b1;
    e.dir  = 1'b1;
    e.b    = 3'd6;
    sb.push_back(e);
    G = 3'b101;
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    checks++;
    if (sb.size() != 0 || POS !== 8'd0 || ERR !== 1'b0 || DIR !== 1'b1 || B !== 3'd6) begin
      fails++;
      $display("[TB] FAIL clr_step: queue=%0d pos=%0d err=%0b dir=%0b b=%0d, required queue=0 pos=0 err=0 dir=1 b=6",
               sb.size(), POS, ERR, DIR, B);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_en_gating_reset();
    ev_t e;
    EN = 1'b0;
    G = 3'b100;
    repeat (4) @(negedge CLK);
    G = 3'b000;
    repeat (4) @(negedge CLK);
    checks++;
    if (B !== 3'd6 || POS !== 8'd0) begin
      fails++;
      $display("[TB] FAIL en_gating: b=%0d pos=%0d, required b=6 pos=0", B, POS);
    end
    e = '0;
    e.errp = 1'b1;
    e.dir  = 1'b1;
    e.err  = 1'b1;
    sb.push_back(e);
    exp_b = 0; exp_err = 1;
    EN = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0 || ERR !== 1'b1 || B !== 3'd0) begin
      fails++;
      $display("[TB] FAIL en_resume: queue=%0d err=%0b b=%0d, required queue=0 err=1 b=0", sb.size(), ERR, B);
    end
    G = 3'b001;
    @(negedge CLK);
    #2;
    reset_n = 1'b0;
    EN = 1'b0;
    #1;
    checks++;
    if ({B, DIR, STEP, ERR, ERR_P, VALID, POS} !== 16'd0) begin
      fails++;
      $display("[TB] FAIL mid_reset: b=%0d dir=%0b step=%0b err=%0b errp=%0b valid=%0b pos=%0d, required all 0",
               B, DIR, STEP, ERR, ERR_P, VALID, POS);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (VALID !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reinit_hold: valid=%0b, required 0", VALID);
    end
    EN = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if (VALID !== 1'b1 || B !== 3'd1 || POS !== 8'd0 || STEP !== 1'b0 || ERR !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reinit: valid=%0b b=%0d pos=%0d step=%0b err=%0b, required valid=1 b=1 pos=0 step=0 err=0",
               VALID, B, POS, STEP, ERR);
    end
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_illegal_jump();
    test_clr_step();
    test_en_gating_reset();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL pending_events: queue=%0d, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
